// File: rtl/btn_onepulse_tx.sv
// Pushbutton front end: 2-flop synchroniser, counter debouncer and a small FSM that
// turns each debounced press into one registered pulse, with optional auto-repeat.
module btn_onepulse_tx #(
  parameter int DB_CYCLES     = 4,
  parameter int HOLD_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 20,
  parameter int REPEAT_EN     = 1,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse,
  output logic btn_level,
  output logic held
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             pulse_q, pulse_d;
  logic             held_q, held_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      pulse_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      pulse_q    <= pulse_d;
      held_q     <= held_d;
    end
  end

  // Level flips only after DB_CYCLES consecutive mismatching synced samples.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    pulse_d    = 1'b0;
    held_d     = held_q;
    if (!level_q) begin
      // Release has priority over any terminal count in the same cycle.
      state_d    = IDLE;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
      held_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pulse_d    = 1'b1;
          hold_cnt_d = '0;
          state_d    = PRESSED;
        end
        PRESSED: begin
          if (hold_cnt_q == HOLD_LAST) begin
            // Terminal count waits a cycle if the previous cycle already pulsed.
            if (REPEAT_EN != 0 && !pulse_q) begin
              pulse_d   = 1'b1;
              rep_cnt_d = '0;
              held_d    = 1'b1;
              state_d   = REPEAT;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
          end
        end
        REPEAT: begin
          if (rep_cnt_q == REP_LAST) begin
            if (!pulse_q) begin
              pulse_d   = 1'b1;
              rep_cnt_d = '0;
            end
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pulse     = pulse_q;
  assign btn_level = level_q;
  assign held      = held_q;

endmodule

// File: tb/tb_btn_onepulse_tx.sv
// Bench for btn_onepulse_tx: directed press/glitch/hold/reset scenarios plus random
// button activity, checked against an event-level model of the debounced button.
module tb_btn_onepulse_tx;

  localparam int DB   = 4;
  localparam int HOLD = 100;
  localparam int REP  = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_raw = 1'b0;
  logic pulse_a, level_a, held_a;
  logic pulse_b, level_b, held_b;
  logic sel_q = 1'b0;
  logic prev_pulse_a = 1'b0;

  always #5 clk = ~clk;

  btn_onepulse_tx #(.REPEAT_EN(1)) dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .pulse(pulse_a), .btn_level(level_a), .held(held_a)
  );

  btn_onepulse_tx #(.REPEAT_EN(0)) dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .pulse(pulse_b), .btn_level(level_b), .held(held_b)
  );

  // Downstream 12/24 toggle FSM driven by the single-pulse instance.
  always @(posedge clk or negedge rst) begin
    if (!rst) sel_q <= 1'b0;
    else if (pulse_b) sel_q <= ~sel_q;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw -> two-sample delay -> "last DB samples all opposite" flips the
  // level; pulses are scheduled by elapsed cycles since the press.
  bit m_s1, m_s2, m_lvl, m_flip;
  bit m_hist[$];
  int m_since = -1;
  bit m_pulse_a, m_pulse_b, m_held;

  always @(posedge clk) begin
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_hist.delete();
      m_since = -1; m_pulse_a = 0; m_pulse_b = 0; m_held = 0;
    end else begin
      m_pulse_a = 0;
      m_pulse_b = 0;
      if (!m_lvl) begin
        m_since = -1;
        m_held  = 0;
      end else if (m_since < 0) begin
        m_since = 0;
        m_pulse_a = 1;
        m_pulse_b = 1;
      end else begin
        m_since++;
        if (m_since >= HOLD && (m_since - HOLD) % REP == 0) m_pulse_a = 1;
        if (m_since >= HOLD) m_held = 1;
      end
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      if (m_hist.size() == DB) begin
        m_flip = 1;
        foreach (m_hist[i]) if (m_hist[i] == m_lvl) m_flip = 0;
        if (m_flip) m_lvl = !m_lvl;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  int npulse_a = 0;
  int npulse_b = 0;
  int nlevel   = 0;

  task automatic tick();
    @(negedge clk);
    check_eq("pulse_a", pulse_a, m_pulse_a);
    check_eq("level_a", level_a, m_lvl);
    check_eq("held_a",  held_a,  m_held);
    check_eq("pulse_b", pulse_b, m_pulse_b);
    check_eq("level_b", level_b, m_lvl);
    check_eq("held_b",  held_b,  0);
    check_eq("no_back2back", pulse_a & prev_pulse_a, 0);
    prev_pulse_a = pulse_a;
    if (pulse_a) npulse_a++;
    if (pulse_b) npulse_b++;
    if (level_a) nlevel++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_pulse", pulse_a, 0);
    check_eq("rst_level", level_a, 0);
    check_eq("rst_held",  held_a,  0);
    ticks(n);
    rst = 1'b1;
  endtask

  int pa0, pb0, len;

  initial begin
    rst = 1'b0;
    btn_raw = 1'b0;
    ticks(3);
    check_eq("reset_pulse", pulse_a, 0);
    check_eq("reset_level", level_a, 0);
    check_eq("reset_held",  held_a,  0);
    rst = 1'b1;
    ticks(5);

    // Steady press: level at edge 6, pulse only after edge 7; held to 200 cycles.
    pa0 = npulse_a; pb0 = npulse_b;
    btn_raw = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 5) check_eq("t1_level_e5", level_a, 0);
      if (k == 6) check_eq("t1_level_e6", level_a, 1);
      if (k == 6) check_eq("t1_pulse_e6", pulse_a, 0);
      if (k == 7) check_eq("t1_pulse_e7", pulse_a, 1);
      if (k == 8) check_eq("t1_pulse_e8", pulse_a, 0);
      if (k == 106) check_eq("t3_held_e106", held_a, 0);
      if (k == 107) check_eq("t3_pulse_e107", pulse_a, 1);
      if (k == 107) check_eq("t3_held_e107", held_a, 1);
      if (k == 127) check_eq("t3_pulse_e127", pulse_a, 1);
    end
    check_eq("t3_pulse_count", npulse_a - pa0, 6);
    check_eq("t4_pulse_count", npulse_b - pb0, 1);
    btn_raw = 1'b0;
    ticks(20);
    check_eq("t3_release_held", held_a, 0);
    check_eq("t3_release_nopulse", npulse_a - pa0, 6);

    // Glitch of 3 raw cycles never reaches the level.
    nlevel = 0; pa0 = npulse_a;
    btn_raw = 1'b1;
    ticks(3);
    btn_raw = 1'b0;
    ticks(12);
    check_eq("t2_level_never", nlevel, 0);
    check_eq("t2_no_pulse", npulse_a - pa0, 0);

    // Reset while in REPEAT with button held, then re-press latency.
    btn_raw = 1'b1;
    ticks(130);
    check_eq("t5_in_repeat", held_a, 1);
    do_reset(2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) check_eq("t5_pulse_e6", pulse_a, 0);
      if (k == 7) check_eq("t5_pulse_e7", pulse_a, 1);
    end
    btn_raw = 1'b0;
    ticks(15);

    // Three clean presses toggle the downstream select 0->1->0->1.
    do_reset(1);
    tick();
    check_eq("t6_sel0", sel_q, 0);
    for (int p = 0; p < 3; p++) begin
      btn_raw = 1'b1;
      ticks(30);
      btn_raw = 1'b0;
      ticks(30);
      check_eq("t6_sel", sel_q, (p + 1) % 2);
    end

    // Random activity: bouncy presses of random length, glitches, occasional reset.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          btn_raw = 1'b1;
          ticks($urandom_range(1, 3));
          btn_raw = 1'b0;
          ticks($urandom_range(1, 10));
        end
        default: begin
          for (int b = 0; b < 6; b++) begin
            btn_raw = 1'($urandom_range(0, 1));
            tick();
          end
          btn_raw = 1'b1;
          len = $urandom_range(5, 260);
          ticks(len);
          if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
          ticks($urandom_range(0, 20));
          btn_raw = 1'b0;
          ticks($urandom_range(10, 40));
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
